decoder_sweep_ctrl: RTL and testbench

//   Sequencer for the structural 2x4 decoder function unit F = (AB' + A'B)(C + D').

---
 rtl/decoder_sweep_ctrl_pkg.sv | 18 +
 rtl/decoder_sweep_ctrl_if.sv | 38 +++
 rtl/decoder_sweep_ctrl_settle_timer.sv | 42 ++++
 rtl/decoder_sweep_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_decoder_sweep_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/decoder_sweep_ctrl_pkg.sv
// Shared types and constants for the decoder sweep sequencer.
// Golden tables encode F = (AB' + A'B)(C + D') with bit i holding F for ABCD = i.
package decoder_sweep_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  localparam logic [15:0] GOLDEN_EN1_DEF = 16'h0DD0;
  localparam logic [15:0] GOLDEN_EN0_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/decoder_sweep_ctrl_if.sv
// Bus between the sweep sequencer, its system host and the decoder function unit.
// pass/fail_idx exist only when SWEEP_CHECK_EN is defined.
interface decoder_sweep_ctrl_if;
  import decoder_sweep_pkg::*;

  logic             start;
  logic             abort;
  logic             dut_f;
  logic             dut_en;
  logic [IDX_W-1:0] dut_abcd;
  logic             busy;
  logic             done;
  logic [15:0]      table_en1;
  logic [15:0]      table_en0;
`ifdef SWEEP_CHECK_EN
  logic             pass;
  logic [4:0]       fail_idx;

  modport master (
    output start, abort, dut_f,
    input  dut_en, dut_abcd, busy, done, table_en1, table_en0, pass, fail_idx
  );
  modport slave (
    input  start, abort, dut_f,
    output dut_en, dut_abcd, busy, done, table_en1, table_en0, pass, fail_idx
  );
`else
  modport master (
    output start, abort, dut_f,
    input  dut_en, dut_abcd, busy, done, table_en1, table_en0
  );
  modport slave (
    input  start, abort, dut_f,
    output dut_en, dut_abcd, busy, done, table_en1, table_en0
  );
`endif

endinterface

// File: rtl/decoder_sweep_ctrl_settle_timer.sv
// Loadable down-counter pacing how long each decoder vector is held.
// expire_o flags the last settle cycle so the next cycle can sample F.
module sweep_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == ONE);

endmodule

// File: rtl/decoder_sweep_ctrl.sv
// Sweeps the decoder unit through 16 codes with en=1 then en=0 and captures both truth tables.
// Optional golden compare (pass/fail_idx) is built when SWEEP_CHECK_EN is defined.
module decoder_sweep_ctrl
  import decoder_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
`ifdef SWEEP_CHECK_EN
  , parameter logic [15:0] GOLDEN_EN1 = GOLDEN_EN1_DEF
  , parameter logic [15:0] GOLDEN_EN0 = GOLDEN_EN0_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_sweep_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  // With no settle time every vector goes straight to its sample cycle.
  localparam sweep_state_e     VEC_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  sweep_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pass_sel_q, pass_sel_d;
  logic [15:0]      table_en1_q, table_en1_d;
  logic [15:0]      table_en0_q, table_en0_d;
  logic             dut_en_q, dut_en_d;
  logic [IDX_W-1:0] dut_abcd_q, dut_abcd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_s;
  logic             dec_s;
  logic             expire_s;
`ifdef SWEEP_CHECK_EN
  logic             mism_q, mism_d;
  logic [4:0]       fail_idx_q, fail_idx_d;
  logic             pass_q, pass_d;
  logic             golden_s;
  logic             mis_now_s;

  assign golden_s  = pass_sel_q ? GOLDEN_EN0[idx_q] : GOLDEN_EN1[idx_q];
  assign mis_now_s = (bus.dut_f != golden_s);
`endif

  sweep_settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_s),
    .value_i  (SETTLE_LD),
    .dec_i    (dec_s),
    .expire_o (expire_s)
  );

  // Next-state, table capture and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_sel_d  = pass_sel_q;
    table_en1_d = table_en1_q;
    table_en0_d = table_en0_q;
    load_s      = 1'b0;
    dec_s       = 1'b0;
`ifdef SWEEP_CHECK_EN
    mism_d      = mism_q;
    fail_idx_d  = fail_idx_q;
    pass_d      = pass_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          table_en1_d = 16'h0000;
          table_en0_d = 16'h0000;
          idx_d       = {IDX_W{1'b0}};
          pass_sel_d  = 1'b0;
          load_s      = 1'b1;
          state_d     = VEC_ENTRY;
`ifdef SWEEP_CHECK_EN
          mism_d      = 1'b0;
          fail_idx_d  = 5'd0;
          pass_d      = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (expire_s) begin
          state_d = SAMPLE;
        end else begin
          dec_s = 1'b1;
        end
      end
      SAMPLE: begin
        // The sample taken in this cycle is kept even when abort arrives with it.
        if (pass_sel_q) begin
          table_en0_d[idx_q] = bus.dut_f;
        end else begin
          table_en1_d[idx_q] = bus.dut_f;
        end
`ifdef SWEEP_CHECK_EN
        if (mis_now_s && !mism_q) begin
          mism_d     = 1'b1;
          fail_idx_d = {pass_sel_q, idx_q};
        end else begin
          mism_d     = mism_q;
        end
`endif
        if (bus.abort) begin
          state_d = IDLE;
        end else if (idx_q != IDX_LAST) begin
          idx_d   = idx_q + IDX_ONE;
          load_s  = 1'b1;
          state_d = VEC_ENTRY;
        end else if (!pass_sel_q) begin
          pass_sel_d = 1'b1;
          idx_d      = {IDX_W{1'b0}};
          load_s     = 1'b1;
          state_d    = VEC_ENTRY;
        end else begin
          state_d = DONE;
`ifdef SWEEP_CHECK_EN
          pass_d  = !(mism_q || mis_now_s);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == SETTLE) || (state_d == SAMPLE)) begin
      busy_d     = 1'b1;
      dut_en_d   = !pass_sel_d;
      dut_abcd_d = idx_d;
    end else begin
      busy_d     = 1'b0;
      dut_en_d   = 1'b0;
      dut_abcd_d = {IDX_W{1'b0}};
    end
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= {IDX_W{1'b0}};
      pass_sel_q  <= 1'b0;
      table_en1_q <= 16'h0000;
      table_en0_q <= 16'h0000;
      dut_en_q    <= 1'b0;
      dut_abcd_q  <= {IDX_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_sel_q  <= pass_sel_d;
      table_en1_q <= table_en1_d;
      table_en0_q <= table_en0_d;
      dut_en_q    <= dut_en_d;
      dut_abcd_q  <= dut_abcd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef SWEEP_CHECK_EN
  // Golden-compare result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mism_q     <= 1'b0;
      fail_idx_q <= 5'd0;
      pass_q     <= 1'b0;
    end else begin
      mism_q     <= mism_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.pass     = pass_q;
  assign bus.fail_idx = fail_idx_q;
`endif

  assign bus.dut_en    = dut_en_q;
  assign bus.dut_abcd  = dut_abcd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_en1 = table_en1_q;
  assign bus.table_en0 = table_en0_q;

endmodule

// File: tb/tb_decoder_sweep_ctrl.sv
// Directed bench for decoder_sweep_ctrl with a behavioural decoder unit and fault injection.
// pass/fail_idx checks are compiled when SWEEP_CHECK_EN is defined.
module tb_decoder_sweep_ctrl;

  localparam int SETTLE    = 1;
  localparam int VEC_CYC   = SETTLE + 1;
  // Start taken at edge N -> done visible after edge N + 32 vectors * VEC_CYC.
  localparam int SWEEP_LAT = 32 * VEC_CYC;

  logic clk = 1'b0;
  logic rst_n;
  bit   fault_on;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  int   n_done;
  int   err_cnt;
  bit   found;

  decoder_sweep_ctrl_if bus();

  decoder_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Decoder unit F = en & (A^B)&(C|~D), optionally stuck at 1 for ABCD=0101.
  assign bus.dut_f = bus.dut_en &
                     ((fault_on && (bus.dut_abcd == 4'd5)) ||
                      ((bus.dut_abcd[3] ^ bus.dut_abcd[2]) && (bus.dut_abcd[1] || !bus.dut_abcd[0])));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_en"},   32'(bus.dut_en),    32'd0);
    check_eq({tag, "_abcd"}, 32'(bus.dut_abcd),  32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy),      32'd0);
    check_eq({tag, "_done"}, 32'(bus.done),      32'd0);
    check_eq({tag, "_t1"},   32'(bus.table_en1), 32'd0);
    check_eq({tag, "_t0"},   32'(bus.table_en0), 32'd0);
`ifdef SWEEP_CHECK_EN
    check_eq({tag, "_pass"}, 32'(bus.pass),      32'd0);
    check_eq({tag, "_fidx"}, 32'(bus.fail_idx),  32'd0);
`endif
  endtask

  // Pulse start, then watch a fixed 200-cycle window for ordering, busy and done.
  task automatic run_sweep(input bit extra_starts, output int lat_o, output int n_done_o);
    int         ord_err;
    int         vec;
    logic [4:0] exp_v;
    ord_err  = 0;
    lat_o    = -1;
    n_done_o = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k < SWEEP_LAT) begin
        vec   = k / VEC_CYC;
        exp_v = {(vec < 16) ? 1'b1 : 1'b0, 4'(vec % 16)};
        if ({bus.dut_en, bus.dut_abcd} !== exp_v || bus.busy !== 1'b1) ord_err++;
      end
      if (bus.done === 1'b1) begin
        n_done_o++;
        if (lat_o < 0) begin
          lat_o = k;
          check_eq("done_en",   32'(bus.dut_en),   32'd0);
          check_eq("done_abcd", 32'(bus.dut_abcd), 32'd0);
          check_eq("done_busy", 32'(bus.busy),     32'd0);
        end
      end
      bus.start = (extra_starts && (k == 10 || k == 40 || k == SWEEP_LAT)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq("order", 32'(ord_err), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    fault_on  = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("rst");
    rst_n = 1'b1;

    err_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_en !== 1'b0) err_cnt++;
    end
    check_eq("idle100", 32'(err_cnt), 32'd0);

    // Clean sweep
    run_sweep(1'b0, lat, n_done);
    check_eq("lat",     32'(lat),           32'(SWEEP_LAT));
    check_eq("n_done",  32'(n_done),        32'd1);
    check_eq("t1",      32'(bus.table_en1), 32'h0DD0);
    check_eq("t0",      32'(bus.table_en0), 32'h0000);
`ifdef SWEEP_CHECK_EN
    check_eq("pass",    32'(bus.pass),      32'd1);
    check_eq("fidx",    32'(bus.fail_idx),  32'd0);
`endif

    // Stuck-at-1 fault at ABCD=0101 during the en=1 pass
    fault_on = 1'b1;
    run_sweep(1'b0, lat, n_done);
    fault_on = 1'b0;
    check_eq("f_lat",   32'(lat),           32'(SWEEP_LAT));
    check_eq("f_t1",    32'(bus.table_en1), 32'h0DF0);
    check_eq("f_t0",    32'(bus.table_en0), 32'h0000);
`ifdef SWEEP_CHECK_EN
    check_eq("f_pass",  32'(bus.pass),      32'd0);
    check_eq("f_fidx",  32'(bus.fail_idx),  32'h05);
`endif

    // Abort during the sample cycle of idx 7, en=1 pass
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if ({bus.dut_en, bus.dut_abcd} === 5'h17) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("ab_reach", 32'(found), 32'd1);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("ab_busy", 32'(bus.busy),     32'd0);
    check_eq("ab_en",   32'(bus.dut_en),   32'd0);
    check_eq("ab_abcd", 32'(bus.dut_abcd), 32'd0);
    err_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) err_cnt++;
    end
    check_eq("ab_nodone", 32'(err_cnt),       32'd0);
    check_eq("ab_t1",     32'(bus.table_en1), 32'h00D0);
    check_eq("ab_t0",     32'(bus.table_en0), 32'h0000);
`ifdef SWEEP_CHECK_EN
    check_eq("ab_pass",   32'(bus.pass),      32'd0);
`endif

    // start and abort together in IDLE: nothing happens, tables kept
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    err_cnt = 0;
    repeat (20) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) err_cnt++;
      @(negedge clk);
    end
    check_eq("sa_idle", 32'(err_cnt),       32'd0);
    check_eq("sa_t1",   32'(bus.table_en1), 32'h00D0);

    // Reset mid-sweep at en=0, idx=3
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if ({bus.dut_en, bus.dut_abcd} === 5'h03 && bus.busy === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("rm_reach", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_quiet("rm");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Restart with start pulses during busy and in the DONE cycle
    run_sweep(1'b1, lat, n_done);
    check_eq("rs_lat",    32'(lat),           32'(SWEEP_LAT));
    check_eq("rs_n_done", 32'(n_done),        32'd1);
    check_eq("rs_t1",     32'(bus.table_en1), 32'h0DD0);
    check_eq("rs_t0",     32'(bus.table_en0), 32'h0000);
`ifdef SWEEP_CHECK_EN
    check_eq("rs_pass",   32'(bus.pass),      32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
